// File: rtl/switch_debouncer.sv
// switch_debouncer
//   Per-channel conditioning of raw switch/pushbutton inputs: a two-flop
//   synchroniser followed by a counter-based debounce FSM. Each channel
//   produces a clean registered level plus one-cycle rise/fall strobes that
//   are registered in the same cycle as the level change.
module switch_debouncer #(
    parameter int N               = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] Raw,
    output logic [N-1:0] Level,
    output logic [N-1:0] Rise,
    output logic [N-1:0] Fall
);

    // Counter width is derived from the debounce length and is not meant to be overridden.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // With a one-cycle debounce a change is accepted straight from the
    // STABLE state, so the WAIT states are never entered.
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_t;

    logic [N-1:0]     s1_r;
    logic [N-1:0]     s2_r;
    state_t           state_r [N];
    logic [CNT_W-1:0] cnt_r   [N];
    logic [N-1:0]     level_r;
    logic [N-1:0]     rise_r;
    logic [N-1:0]     fall_r;

    // Two-flop synchroniser; only s2_r is ever seen by the debounce FSM.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_r <= {N{1'b0}};
            s2_r <= {N{1'b0}};
        end else begin
            s1_r <= Raw;
            s2_r <= s1_r;
        end
    end

    // Per-channel debounce FSM; level and strobes are registered together on acceptance.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= STABLE_LO;
                cnt_r[i]   <= CNT_ZERO;
            end
            level_r <= {N{1'b0}};
            rise_r  <= {N{1'b0}};
            fall_r  <= {N{1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                // Strobes are single-cycle: cleared unless this cycle accepts a change.
                rise_r[i] <= 1'b0;
                fall_r[i] <= 1'b0;
                case (state_r[i])
                    STABLE_LO: begin
                        if (s2_r[i]) begin
                            if (SINGLE_CYCLE) begin
                                state_r[i] <= STABLE_HI;
                                level_r[i] <= 1'b1;
                                rise_r[i]  <= 1'b1;
                                cnt_r[i]   <= CNT_ZERO;
                            end else begin
                                state_r[i] <= WAIT_HI;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end else begin
                            cnt_r[i] <= CNT_ZERO;
                        end
                    end
                    WAIT_HI: begin
                        if (!s2_r[i]) begin
                            // Bounce back to low: discard the partial count, no strobe.
                            state_r[i] <= STABLE_LO;
                            cnt_r[i]   <= CNT_ZERO;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= STABLE_HI;
                            level_r[i] <= 1'b1;
                            rise_r[i]  <= 1'b1;
                            cnt_r[i]   <= CNT_ZERO;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    STABLE_HI: begin
                        if (!s2_r[i]) begin
                            if (SINGLE_CYCLE) begin
                                state_r[i] <= STABLE_LO;
                                level_r[i] <= 1'b0;
                                fall_r[i]  <= 1'b1;
                                cnt_r[i]   <= CNT_ZERO;
                            end else begin
                                state_r[i] <= WAIT_LO;
                                cnt_r[i]   <= CNT_ONE;
                            end
                        end else begin
                            cnt_r[i] <= CNT_ZERO;
                        end
                    end
                    WAIT_LO: begin
                        if (s2_r[i]) begin
                            // Bounce back to high: discard the partial count, no strobe.
                            state_r[i] <= STABLE_HI;
                            cnt_r[i]   <= CNT_ZERO;
                        end else if (cnt_r[i] == CNT_LAST) begin
                            state_r[i] <= STABLE_LO;
                            level_r[i] <= 1'b0;
                            fall_r[i]  <= 1'b1;
                            cnt_r[i]   <= CNT_ZERO;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover to the reset state.
                        state_r[i] <= STABLE_LO;
                        cnt_r[i]   <= CNT_ZERO;
                        level_r[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Level = level_r;
    assign Rise  = rise_r;
    assign Fall  = fall_r;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
//   Table-driven directed vectors, hand-written reset sequences and a
//   randomized phase compared against a sliding-window reference model.
module tb_switch_debouncer;

    localparam int N = 2;
    localparam int D = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [N-1:0] Raw;
    logic [N-1:0] Level;
    logic [N-1:0] Rise;
    logic [N-1:0] Fall;

    int total_checks  = 0;
    int passed_checks = 0;

    switch_debouncer #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Raw   (Raw),
        .Level (Level),
        .Rise  (Rise),
        .Fall  (Fall)
    );

    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // Reference model: the value seen by the debouncer is Raw delayed two
    // edges; a channel's level flips once the last D seen values all hold
    // the opposite value of the current level.
    // ------------------------------------------------------------------
    logic [N-1:0] m_pipe [$];
    logic [N-1:0] m_win  [$];
    logic [N-1:0] m_level;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            m_win.delete();
            for (int k = 0; k < D; k++) m_win.push_back('0);
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            logic [N-1:0] seen;
            seen = m_pipe.pop_front();
            m_pipe.push_back(Raw);
            m_win.push_back(seen);
            if (m_win.size() > D) void'(m_win.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int ch = 0; ch < N; ch++) begin
                bit all_opposite;
                all_opposite = 1'b1;
                foreach (m_win[k]) if (m_win[k][ch] == m_level[ch]) all_opposite = 1'b0;
                if (all_opposite) begin
                    m_level[ch] = ~m_level[ch];
                    if (m_level[ch]) m_rise[ch] = 1'b1;
                    else             m_fall[ch] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
        total_checks++;
        if (act !== exp)
            $display("FAIL %s: got level/rise/fall=%b required %b at %0t", name, act, exp, $time);
        else
            passed_checks++;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [N-1:0] raw;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N-1:0] ri, input logic [N-1:0] f, input int n);
        vec_t v;
        v.raw = r; v.lvl = l; v.rise = ri; v.fall = f;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    // After release, count edges until Level reaches 11; expect full latency.
    task automatic measure_rise(input string name);
        int hit;
        logic [N-1:0] rise_hit;
        logic [N-1:0] rise_next;
        hit = 0;
        rise_hit = '0;
        rise_next = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            @(negedge Clk);
            if (hit == 0 && Level == 2'b11) begin
                hit = e;
                rise_hit = Rise;
            end else if (hit != 0 && e == hit + 1) begin
                rise_next = Rise;
            end
        end
        check({name, "_latency"}, 6'(hit), 6'(1 + 1 + D));
        check({name, "_rise"},    {4'b0000, rise_hit},  {4'b0000, 2'b11});
        check({name, "_rise_off"}, {4'b0000, rise_next}, 6'b000000);
    endtask

    initial begin
        Raw   = 2'b00;
        Reset = 1'b0;
        #2 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("reset_state", {Level, Rise, Fall}, 6'b000000);
        Reset = 1'b0;

        // settle low
        add(2'b00, 2'b00, 2'b00, 2'b00, 6);
        // clean rise on ch0
        add(2'b01, 2'b00, 2'b00, 2'b00, 5);
        add(2'b01, 2'b01, 2'b01, 2'b00, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1);
        // simultaneous swap: ch1 rises, ch0 falls
        add(2'b10, 2'b01, 2'b00, 2'b00, 5);
        add(2'b10, 2'b10, 2'b10, 2'b01, 1);
        add(2'b10, 2'b10, 2'b00, 2'b00, 1);
        // ch0 bounce 1,0,1,1,0 then steady 1
        add(2'b11, 2'b10, 2'b00, 2'b00, 1);
        add(2'b10, 2'b10, 2'b00, 2'b00, 1);
        add(2'b11, 2'b10, 2'b00, 2'b00, 2);
        add(2'b10, 2'b10, 2'b00, 2'b00, 1);
        add(2'b11, 2'b10, 2'b00, 2'b00, 5);
        add(2'b11, 2'b11, 2'b01, 2'b00, 1);
        add(2'b11, 2'b11, 2'b00, 2'b00, 1);
        // ch1 falls
        add(2'b01, 2'b11, 2'b00, 2'b00, 5);
        add(2'b01, 2'b01, 2'b00, 2'b10, 1);
        add(2'b01, 2'b01, 2'b00, 2'b00, 1);
        // ch1 three-cycle high glitch: rejected
        add(2'b11, 2'b01, 2'b00, 2'b00, 3);
        add(2'b01, 2'b01, 2'b00, 2'b00, 6);
        // ch1 real rise afterwards: full latency from a restarted count
        add(2'b11, 2'b01, 2'b00, 2'b00, 5);
        add(2'b11, 2'b11, 2'b10, 2'b00, 1);
        add(2'b11, 2'b11, 2'b00, 2'b00, 1);

        foreach (tbl[k]) begin
            Raw = tbl[k].raw;
            @(negedge Clk);
            check($sformatf("vec%0d", k), {Level, Rise, Fall}, {tbl[k].lvl, tbl[k].rise, tbl[k].fall});
        end

        // Asynchronous reset mid-cycle with Raw=11: outputs clear before the next edge.
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1 check("async_reset", {Level, Rise, Fall}, 6'b000000);
        @(negedge Clk);
        Reset = 1'b0;
        measure_rise("post_reset");

        // Reset pulse while both channels are in WAIT_HI with count 2.
        Raw = 2'b00;
        repeat (8) @(negedge Clk);
        check("fall_settled", {Level, Rise, Fall}, 6'b000000);
        Raw = 2'b11;
        repeat (4) @(negedge Clk);
        check("wait_hi_no_level", {Level, Rise, Fall}, 6'b000000);
        #2 Reset = 1'b1;
        #1 check("reset_mid_wait", {Level, Rise, Fall}, 6'b000000);
        @(negedge Clk);
        Reset = 1'b0;
        measure_rise("mid_wait");

        // Randomized phase against the reference model.
        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] r;
            r = Raw;
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 7) == 0) r[ch] = ~r[ch];
            Raw   = r;
            Reset = ($urandom_range(0, 199) == 0);
            @(negedge Clk);
            check($sformatf("rand%0d", i), {Level, Rise, Fall}, {m_level, m_rise, m_fall});
        end
        Reset = 1'b0;

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
